ecp5pll_phase_sweep: RTL and testbench

- Automatic successor to the button-driven PLL phase stepper used in SDRAM memtest tops.
- Sweeps the SDRAM chip-clock phase through all C_STEPS positions of the ECP5 PLL dynamic phase port and runs the memory tester for a dwell window at each step.
- Builds a pass/fail map, finds the longest circular passing window, then steps the PLL to the window centre.
- Manual inc/dec remains available when not sweeping; sits between the btn debouncer, the sdram ecp5pll and mem_tester.

---
 rtl/ecp5pll_phase_sweep.sv | 185 ++++++++++++++++++
 tb/tb_ecp5pll_phase_sweep.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecp5pll_phase_sweep.sv
// ECP5 PLL phase sweeper: steps the SDRAM clock phase through every position, scores each with
// the memory tester, then parks the phase at the centre of the longest circular passing window.
module ecp5pll_phase_sweep #(
  parameter int C_STEPS      = 16,
  parameter int C_PULSE      = 4,
  parameter int C_SETTLE     = 1024,
  parameter int C_DWELL      = 1048576,
  parameter int C_MIN_PASS   = 1,
  parameter int C_INIT_PHASE = 0,
  localparam int C_PW        = $clog2(C_STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               inc,
  input  logic               dec,
  input  logic [31:0]        passcount,
  input  logic [31:0]        failcount,
  output logic               phasedir,
  output logic               phasestep,
  output logic               phaseloadreg,
  output logic               tester_rst_n,
  output logic [C_PW-1:0]    phase,
  output logic [C_STEPS-1:0] pass_map,
  output logic [C_PW-1:0]    best_start,
  output logic [C_PW:0]      best_len,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [3:0]         dbg_state
);

  // Handshake: start/inc/dec are single-cycle strobes without a ready; they are accepted only
  // while busy is low (IDLE or DONE) and dropped otherwise. start beats inc/dec; inc+dec cancel.

  typedef enum logic [3:0] {
    S_IDLE, S_DONE, S_SETUP, S_HI, S_LO, S_SETTLE, S_DWELL, S_EVAL, S_SCAN, S_PICK, S_SEEK
  } state_t;

  localparam logic [C_PW-1:0] LAST_K     = C_PW'(C_STEPS - 1);
  localparam logic [C_PW:0]   FULL       = (C_PW+1)'(C_STEPS);
  localparam logic [C_PW:0]   SCAN_LAST  = (C_PW+1)'(2 * C_STEPS - 1);
  localparam logic [31:0]     PULSE_LAST = 32'(C_PULSE - 1);
  localparam logic [31:0]     SETTLE_LAST = 32'(C_SETTLE - 1);
  localparam logic [31:0]     DWELL_LAST = 32'(C_DWELL - 1);

  state_t            state, state_d, ret, ret_d;
  logic              dir_d;
  logic [31:0]       cnt, cnt_d;
  logic [C_PW-1:0]   p0, k, target, scan_pos;
  logic [C_PW:0]     scan_i, run, run_nx;
  logic [31:0]       snap_p, snap_f;
  logic              eval_pass, scan_bit;

  // ret remembers where a step primitive hands control back to.
  always_comb begin
    state_d = state;
    ret_d   = ret;
    dir_d   = phasedir;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
        end else if (inc ^ dec) begin
          state_d = S_SETUP;
          dir_d   = dec;
          ret_d   = state;
        end
      end
      S_SETUP:  state_d = S_HI;
      S_HI:     if (cnt == PULSE_LAST) state_d = S_LO;
      S_LO:     if (cnt == PULSE_LAST) state_d = ret;
      S_SETTLE: if (cnt == SETTLE_LAST) state_d = S_DWELL;
      S_DWELL:  if (cnt == DWELL_LAST) state_d = S_EVAL;
      S_EVAL: begin
        state_d = S_SETUP;
        dir_d   = 1'b0;
        ret_d   = (k == LAST_K) ? S_SCAN : S_SETTLE;
      end
      S_SCAN:   if (scan_i == SCAN_LAST) state_d = S_PICK;
      S_PICK:   state_d = (best_len == '0 || best_len == FULL) ? S_DONE : S_SEEK;
      S_SEEK: begin
        if (phase == target) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETUP;
          dir_d   = 1'b0;
          ret_d   = S_SEEK;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  assign cnt_d = (state_d != state) ? '0 : cnt + 32'd1;

  assign scan_pos = p0 + scan_i[C_PW-1:0];
  assign scan_bit = pass_map[scan_pos];

  always_comb begin
    run_nx = '0;
    if (scan_bit) run_nx = (run == FULL) ? run : run + (C_PW+1)'(1);
  end

  // Counter differences are taken mod 2^32 so tester counter wrap is harmless.
  assign eval_pass = ((failcount - snap_f) == 32'd0) &&
                     ((passcount - snap_p) >= 32'(C_MIN_PASS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ret          <= S_IDLE;
      cnt          <= '0;
      phasedir     <= 1'b0;
      phasestep    <= 1'b0;
      tester_rst_n <= 1'b1;
      phase        <= C_PW'(C_INIT_PHASE);
      pass_map     <= '0;
      best_start   <= '0;
      best_len     <= '0;
      fail         <= 1'b0;
      p0           <= '0;
      k            <= '0;
      target       <= '0;
      snap_p       <= '0;
      snap_f       <= '0;
      scan_i       <= '0;
      run          <= '0;
    end else begin
      state        <= state_d;
      ret          <= ret_d;
      cnt          <= cnt_d;
      phasedir     <= dir_d;
      phasestep    <= (state_d == S_HI);
      tester_rst_n <= (state_d != S_SETTLE);
      if (state == S_HI && state_d == S_LO)
        phase <= phasedir ? phase - C_PW'(1) : phase + C_PW'(1);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            p0         <= phase;
            pass_map   <= '0;
            fail       <= 1'b0;
            k          <= '0;
            best_len   <= '0;
            best_start <= '0;
          end
        end
        S_DWELL: begin
          if (cnt == 32'd0) begin
            snap_p <= passcount;
            snap_f <= failcount;
          end
        end
        S_EVAL: begin
          pass_map[phase] <= eval_pass;
          if (k != LAST_K) k <= k + C_PW'(1);
          scan_i <= '0;
          run    <= '0;
        end
        S_SCAN: begin
          run    <= run_nx;
          scan_i <= scan_i + (C_PW+1)'(1);
          // Strictly greater keeps the earliest window on ties.
          if (run_nx > best_len) begin
            best_len   <= run_nx;
            best_start <= scan_pos - run_nx[C_PW-1:0] + C_PW'(1);
          end
        end
        S_PICK: begin
          if (best_len == '0) fail <= 1'b1;
          else if (best_len == FULL) best_start <= p0;
          else target <= best_start + best_len[C_PW:1];
        end
        default: ;
      endcase
    end
  end

  assign phaseloadreg = 1'b0;
  assign busy         = (state != S_IDLE) && (state != S_DONE);
  assign done         = (state == S_DONE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_ecp5pll_phase_sweep.sv
// Bench for ecp5pll_phase_sweep: manual step vector table, directed and random sweeps against a
// window-enumerating reference model, plus reset and busy-ignore sequences.
`timescale 1ns/1ps
module tb_ecp5pll_phase_sweep;
  localparam int N      = 16;
  localparam int PW     = 4;
  localparam int PULSE  = 4;
  localparam int SETTLE = 6;
  localparam int DWELL  = 12;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [31:0] passcount = 32'hFFFF_FFF8;
  logic [31:0] failcount = 32'hFFFF_FFFA;
  logic phasedir, phasestep, phaseloadreg, tester_rst_n;
  logic [PW-1:0] phase, best_start;
  logic [N-1:0] pass_map;
  logic [PW:0] best_len;
  logic busy, done, fail;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  ecp5pll_phase_sweep #(
    .C_STEPS(N), .C_PULSE(PULSE), .C_SETTLE(SETTLE), .C_DWELL(DWELL),
    .C_MIN_PASS(1), .C_INIT_PHASE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inc(inc), .dec(dec),
    .passcount(passcount), .failcount(failcount),
    .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
    .tester_rst_n(tester_rst_n), .phase(phase), .pass_map(pass_map),
    .best_start(best_start), .best_len(best_len), .busy(busy), .done(done),
    .fail(fail), .dbg_state(dbg_state)
  );

  int n_vec = 0, n_err = 0;
  int mphase = 0;
  logic [N-1:0] good_map = '1;

  // Memory tester model: counts passes on good phases, fails on bad ones, while out of reset.
  always @(negedge clk) begin
    if (tester_rst_n) begin
      if (good_map[phase]) passcount = passcount + 32'd1;
      else failcount = failcount + 32'd1;
    end
  end

  // Pulse monitor: counts PLL steps and checks pulse shape and phasedir setup/hold.
  int pulses = 0, hi_len = 0, lo_len = 100, bad_width = 0, dir_glitch = 0;
  logic ps_prev = 1'b0, dir_prev = 1'b0, dir_at = 1'b0;
  always @(negedge clk) begin
    if (phasestep) begin
      if (!ps_prev) begin
        pulses++;
        if (phasedir != dir_prev) dir_glitch++;
        if (lo_len < PULSE + 1) bad_width++;
        dir_at = phasedir;
        hi_len = 0;
      end
      hi_len++;
      if (phasedir != dir_at) dir_glitch++;
    end else begin
      if (ps_prev && hi_len != PULSE) bad_width++;
      lo_len = ps_prev ? 1 : lo_len + 1;
    end
    ps_prev  = phasestep;
    dir_prev = phasedir;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: enumerate maximal circular pass windows; the longest wins, ties go to the one
  // whose end is reached first when reading the map starting at p0.
  function automatic void ref_best(input logic [N-1:0] m, input int p0,
                                   output int bs, output int bl);
    int best_e, len, e;
    bs = 0; bl = 0; best_e = 4 * N;
    if (&m) begin
      bs = p0; bl = N;
    end else begin
      for (int s = 0; s < N; s++) begin
        if (m[s] && !m[(s + N - 1) % N]) begin
          len = 0;
          while (m[(s + len) % N]) len++;
          e = (s - p0 + N) % N + len - 1;
          if (len > bl || (len == bl && e < best_e)) begin
            bs = s; bl = len; best_e = e;
          end
        end
      end
    end
  endfunction

  task automatic step_up();
    int cyc;
    @(negedge clk); inc = 1'b1;
    @(negedge clk); inc = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin @(negedge clk); cyc++; end
    mphase = (mphase + 1) % N;
    chk("step_up_phase", 32'(phase), 32'(mphase));
  endtask

  task automatic do_sweep(input logic [N-1:0] gm, input bit noise, input bit poke);
    int p0, bs, bl, tgt, nseek, base, cyc;
    p0 = mphase;
    good_map = gm;
    ref_best(gm, p0, bs, bl);
    tgt = (bl > 0 && bl < N) ? (bs + bl / 2) % N : p0;
    nseek = (tgt - p0 + N) % N;
    base = pulses;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (poke) begin
      @(negedge clk); inc = 1'b1;
      @(negedge clk); inc = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0; dec = 1'b1;
      @(negedge clk); dec = 1'b0;
      repeat (6) @(negedge clk);
      chk("poke_no_pulse", 32'(pulses - base), 32'd0);
      chk("poke_busy", 32'(busy), 32'd1);
    end
    cyc = 0;
    while (!done && cyc < 4000) begin
      start = 1'b0; inc = 1'b0; dec = 1'b0;
      if (noise && busy && $urandom_range(0, 30) == 0) begin
        case ($urandom_range(0, 2))
          0: start = 1'b1;
          1: inc = 1'b1;
          default: dec = 1'b1;
        endcase
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; inc = 1'b0; dec = 1'b0;
    chk("sweep_done", 32'(done), 32'd1);
    chk("sweep_pass_map", 32'(pass_map), 32'(gm));
    chk("sweep_best_len", 32'(best_len), 32'(bl));
    if (bl > 0) chk("sweep_best_start", 32'(best_start), 32'(bs));
    chk("sweep_fail", 32'(fail), 32'(bl == 0));
    chk("sweep_phase", 32'(phase), 32'(tgt));
    chk("sweep_pulses", 32'(pulses - base), 32'(N + nseek));
    chk("sweep_busy", 32'(busy), 32'd0);
    mphase = tgt;
  endtask

  typedef struct {
    logic inc_v;
    logic dec_v;
    int   exp_phase;
    logic exp_dir;
    int   n_pulse;
  } vec_t;
  vec_t vt [12];

  initial begin
    int p0, base, cyc;
    vt[0]  = '{1'b1, 1'b0, 1,  1'b0, 1};
    vt[1]  = '{1'b1, 1'b0, 2,  1'b0, 1};
    vt[2]  = '{1'b1, 1'b0, 3,  1'b0, 1};
    vt[3]  = '{1'b1, 1'b0, 4,  1'b0, 1};
    vt[4]  = '{1'b1, 1'b1, 4,  1'b0, 0};
    vt[5]  = '{1'b0, 1'b1, 3,  1'b1, 1};
    vt[6]  = '{1'b0, 1'b1, 2,  1'b1, 1};
    vt[7]  = '{1'b0, 1'b1, 1,  1'b1, 1};
    vt[8]  = '{1'b0, 1'b1, 0,  1'b1, 1};
    vt[9]  = '{1'b0, 1'b1, 15, 1'b1, 1};
    vt[10] = '{1'b1, 1'b0, 0,  1'b0, 1};
    vt[11] = '{1'b1, 1'b1, 0,  1'b0, 0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset state code %0d", dbg_state);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_phasedir", 32'(phasedir), 32'd0);
    chk("rst_phasestep", 32'(phasestep), 32'd0);
    chk("rst_phaseloadreg", 32'(phaseloadreg), 32'd0);
    chk("rst_tester_rst_n", 32'(tester_rst_n), 32'd1);
    chk("rst_pass_map", 32'(pass_map), 32'd0);
    chk("rst_best_start", 32'(best_start), 32'd0);
    chk("rst_best_len", 32'(best_len), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      base = pulses;
      @(negedge clk); inc = vt[v].inc_v; dec = vt[v].dec_v;
      @(negedge clk); inc = 1'b0; dec = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin @(negedge clk); cyc++; end
      chk($sformatf("vec%0d_phase", v), 32'(phase), 32'(vt[v].exp_phase));
      chk($sformatf("vec%0d_phasedir", v), 32'(phasedir), 32'(vt[v].exp_dir));
      chk($sformatf("vec%0d_pulses", v), 32'(pulses - base), 32'(vt[v].n_pulse));
      chk($sformatf("vec%0d_busy_cycles", v), 32'(cyc), 32'((2 * PULSE + 1) * vt[v].n_pulse));
      chk($sformatf("vec%0d_done", v), 32'(done), 32'd0);
    end
    mphase = vt[11].exp_phase;

    do_sweep(16'hFF87, 1'b0, 1'b0);
    do_sweep(16'h0000, 1'b0, 1'b0);
    while (mphase != 5) step_up();
    do_sweep(16'hFFFF, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      int ns;
      ns = $urandom_range(0, 3);
      for (int j = 0; j < ns; j++) step_up();
      do_sweep(16'($urandom_range(0, 65535)), 1'b1, 1'b0);
    end
    chk("pulse_width_errors", 32'(bad_width), 32'd0);
    chk("phasedir_setup_hold_errors", 32'(dir_glitch), 32'd0);
    chk("phaseloadreg_const", 32'(phaseloadreg), 32'd0);

    // Reset while dwelling on step 7 of a sweep.
    p0 = mphase;
    good_map = '1;
    base = pulses;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (pulses - base < 7 && cyc < 2000) begin @(negedge clk); cyc++; end
    while (tester_rst_n && cyc < 2000) begin @(negedge clk); cyc++; end
    while (!tester_rst_n && cyc < 2000) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    chk("dwell7_busy", 32'(busy), 32'd1);
    chk("dwell7_phase", 32'(phase), 32'((p0 + 7) % N));
    chk("dwell7_pulses", 32'(pulses - base), 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_phase", 32'(phase), 32'd0);
    chk("midrst_phasestep", 32'(phasestep), 32'd0);
    chk("midrst_tester_rst_n", 32'(tester_rst_n), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pass_map", 32'(pass_map), 32'd0);
    rst_n = 1'b1;
    mphase = 0;
    @(negedge clk);

    // Reset while phasestep is high must drop it on the same edge.
    @(negedge clk); inc = 1'b1;
    @(negedge clk); inc = 1'b0;
    cyc = 0;
    while (!phasestep && cyc < 50) begin @(negedge clk); cyc++; end
    chk("hi_seen", 32'(phasestep), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("hirst_phasestep", 32'(phasestep), 32'd0);
    chk("hirst_busy", 32'(busy), 32'd0);
    chk("hirst_phase", 32'(phase), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Strobes while busy are ignored and the sweep completes unchanged.
    do_sweep(16'hFF87, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
